subtrator_serial_8bits: RTL and testbench

SUBTRATOR_SERIAL_8BITS -- requirements
Module: subtrator_serial_8bits

---
 rtl/subtrator_pkg.sv | 13 +
 rtl/subtrator_completo.sv | 14 +
 rtl/subtrator_serial_8bits.sv | 131 +++++++++++++
 tb/tb_subtrator_serial_8bits.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/subtrator_pkg.sv
// Shared types and defaults for the bit-serial subtractor.
// Holds the FSM state encoding and the default operand width.
package subtrator_pkg;

    localparam int WIDTH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FIM   = 2'd2
    } state_t;

endpackage

// File: rtl/subtrator_completo.sv
// One-bit full subtractor cell: computes a - b - borrow_in.
// Shared by every bit position of the serial datapath.
module subtrator_completo (
    input  logic A,
    input  logic B,
    input  logic B_in,
    output logic S,
    output logic B_out
);

    assign S     = A ^ B ^ B_in;
    assign B_out = (~A & B) | (~(A ^ B) & B_in);

endmodule

// File: rtl/subtrator_serial_8bits.sv
// Bit-serial A-B subtractor, LSB first, one bit per clock through a single cell.
// Define SUBTRATOR_FLAGS_EN to build the zero (Z) and signed-overflow (OVF) flags.
module subtrator_serial_8bits
    import subtrator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] S,
    output logic             B_out,
    output logic             BUSY,
    output logic             DONE,
    output logic             Z,
    output logic             OVF
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    state_t             r_state;
    state_t             w_next_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [WIDTH-1:0]   r_sh;
    logic               r_bw;
    logic [CNT_W-1:0]   r_cnt;
    logic               w_diff;
    logic               w_bw_next;
    logic               w_last;
    logic               w_capture;
    logic [WIDTH-1:0]   w_result;

    subtrator_completo u_cell (
        .A     (r_a[0]),
        .B     (r_b[0]),
        .B_in  (r_bw),
        .S     (w_diff),
        .B_out (w_bw_next)
    );

    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_capture = (r_state == IDLE) && START;
    assign w_result  = {w_diff, r_sh[WIDTH-1:1]};

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= IDLE;
        else     r_state <= w_next_state;
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        BUSY         = 1'b0;
        DONE         = 1'b0;
        case (r_state)
            IDLE:  if (START) w_next_state = SHIFT;
            SHIFT: begin
                BUSY = 1'b1;
                if (w_last) w_next_state = FIM;
            end
            FIM: begin
                DONE         = 1'b1;
                w_next_state = IDLE;
            end
            default: w_next_state = IDLE;
        endcase
    end

    // S/B_out load only on the final shift, so partial differences never appear on S.
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a   <= '0;
            r_b   <= '0;
            r_sh  <= '0;
            r_bw  <= 1'b0;
            r_cnt <= '0;
            S     <= '0;
            B_out <= 1'b0;
        end else if (w_capture) begin
            r_a   <= A;
            r_b   <= B;
            r_sh  <= '0;
            r_bw  <= 1'b0;
            r_cnt <= '0;
        end else if (r_state == SHIFT) begin
            r_a   <= r_a >> 1;
            r_b   <= r_b >> 1;
            r_sh  <= w_result;
            r_bw  <= w_bw_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
                S     <= w_result;
                B_out <= w_bw_next;
            end
        end
    end

`ifdef SUBTRATOR_FLAGS_EN
    logic r_a_msb;
    logic r_b_msb;
    logic r_z;
    logic r_ovf;

    // Operand sign bits are kept aside because the shift registers discard them.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_a_msb <= 1'b0;
            r_b_msb <= 1'b0;
            r_z     <= 1'b0;
            r_ovf   <= 1'b0;
        end else if (w_capture) begin
            r_a_msb <= A[WIDTH-1];
            r_b_msb <= B[WIDTH-1];
        end else if ((r_state == SHIFT) && w_last) begin
            r_z   <= (w_result == '0);
            r_ovf <= (r_a_msb != r_b_msb) && (w_result[WIDTH-1] != r_a_msb);
        end
    end

    assign Z   = r_z;
    assign OVF = r_ovf;
`else
    assign Z   = 1'b0;
    assign OVF = 1'b0;
`endif

endmodule

// File: tb/tb_subtrator_serial_8bits.sv
// Scoreboard bench for subtrator_serial_8bits: directed vectors push expected
// results; a negedge monitor pops one entry per DONE pulse and compares.
module tb_subtrator_serial_8bits;

    localparam int WIDTH = 8;
`ifdef SUBTRATOR_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    typedef struct {
        logic [WIDTH-1:0] s;
        logic             bo;
        logic             z;
        logic             ovf;
        int               done_cyc;
    } exp_t;

    logic             CLK = 1'b0;
    logic             RST = 1'b1;
    logic             START = 1'b0;
    logic [WIDTH-1:0] A = '0;
    logic [WIDTH-1:0] B = '0;
    logic [WIDTH-1:0] S;
    logic             B_out, BUSY, DONE, Z, OVF;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    exp_t sb[$];

    subtrator_serial_8bits #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST   (RST),
        .START (START),
        .A     (A),
        .B     (B),
        .S     (S),
        .B_out (B_out),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .Z     (Z),
        .OVF   (OVF)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Called at the negedge just before the edge that accepts START; flags are
    // given for the flags build and forced to 0 otherwise.
    task automatic expect_op(input logic [WIDTH-1:0] s, input logic bo, input logic z,
                             input logic ovf, input int extra);
        exp_t e;
        e.s        = s;
        e.bo       = bo;
        e.z        = FLAGS ? z : 1'b0;
        e.ovf      = FLAGS ? ovf : 1'b0;
        e.done_cyc = cyc + 1 + WIDTH + extra;
        sb.push_back(e);
    endtask

    task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic [WIDTH-1:0] s, input logic bo, input logic z, input logic ovf);
        A     = a;
        B     = b;
        START = 1'b1;
        expect_op(s, bo, z, ovf, 0);
        @(negedge CLK);
        START = 1'b0;
    endtask

    task automatic drain(input string name, input int bound);
        for (int i = 0; i < bound && sb.size() > 0; i++) @(negedge CLK);
        check(name, sb.size(), 0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_S"},     S,     '0);
        check({tag, "_Bout"},  B_out, 1'b0);
        check({tag, "_BUSY"},  BUSY,  1'b0);
        check({tag, "_DONE"},  DONE,  1'b0);
        check({tag, "_Z"},     Z,     1'b0);
        check({tag, "_OVF"},   OVF,   1'b0);
    endtask

    // Monitor: every DONE must match the oldest outstanding request.
    always @(negedge CLK) begin
        if (!RST && DONE) begin
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("res_S",    S,     e.s);
                check("res_Bout", B_out, e.bo);
                check("res_Z",    Z,     e.z);
                check("res_OVF",  OVF,   e.ovf);
                check("done_cyc", cyc,   e.done_cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge CLK);
        check_all_zero("reset");

        // First START accepted on the first edge after reset release.
        RST = 1'b0;
        issue(8'h50, 8'h20, 8'h30, 1'b0, 1'b0, 1'b0);
        drain("drain_50_20", 30);
        issue(8'h20, 8'h50, 8'hD0, 1'b1, 1'b0, 1'b0);
        drain("drain_20_50", 30);
        issue(8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1);
        drain("drain_80_01", 30);

        // Equal operands, plus an ignored START with new operands mid-shift.
        issue(8'h3C, 8'h3C, 8'h00, 1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge CLK);
        A     = 8'hFF;
        B     = 8'h00;
        START = 1'b1;
        check("busy_mid_shift", BUSY, 1'b1);
        @(negedge CLK);
        START = 1'b0;
        check("S_held_in_shift", S, 8'h7F);
        drain("drain_3C_3C", 30);

        // Abort mid-shift: outputs clear at once, no DONE for the aborted op.
        @(negedge CLK);
        A     = 8'h55;
        B     = 8'h11;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        repeat (3) @(negedge CLK);
        @(posedge CLK);
        #2 RST = 1'b1;
        #1 check_all_zero("abort");
        A     = 8'h01;
        B     = 8'h02;
        START = 1'b1;
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        expect_op(8'hFF, 1'b1, 1'b0, 1'b0, 0);
        @(negedge CLK);
        START = 1'b0;
        drain("drain_01_02", 30);

        // START held high: one accepted operation every WIDTH+2 cycles.
        @(negedge CLK);
        A     = 8'h7F;
        B     = 8'h80;
        START = 1'b1;
        for (int k = 0; k < 3; k++) expect_op(8'hFF, 1'b1, 1'b0, 1'b1, k * (WIDTH + 2));
        drain("drain_b2b", 60);
        START = 1'b0;
        repeat (12) @(negedge CLK);
        check("idle_after_b2b", BUSY, 1'b0);
        check("no_extra_done", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
